// File: rtl/crystal_chain_check.sv
`timescale 1ns/1ps
// crystal_chain_check
//   Validates the eight crystal-to-GPIO-line mappings from the crystal scan
//   stage. It walks the snapshot one slot per clock and checks that the lines
//   form a permutation of 0..7. It also counts ordered links, where a slot's
//   line equals the previous slot's line plus LINK_STEP (mod 8). Latency is
//   fixed: start at E0, slots at E1..E8, results and a done pulse at E9.
//
// Ports
//   system_clk                     rising-edge clock
//   rst_n                          asynchronous active-low reset
//   start                          request a check (sampled only when idle)
//   crystal_A_line                 GPIO line of slot 0
//   crystal_2_line..crystal_8_line GPIO lines of slots 1..7
//   busy                           high while a check is in flight
//   done                           one-cycle pulse when results update
//   chain_valid                    all lines in range and distinct
//   power_level                    ordered-link count, 0 when chain invalid
//   error_code                     0 none, 1 out of range, 2 duplicate
//   bad_slot                       slot of the first error (0 if none)
module crystal_chain_check #(
   parameter logic [2:0] LINK_STEP = 3'd1
) (
   input  logic       system_clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] crystal_A_line,
   input  logic [3:0] crystal_2_line,
   input  logic [3:0] crystal_3_line,
   input  logic [3:0] crystal_4_line,
   input  logic [3:0] crystal_5_line,
   input  logic [3:0] crystal_6_line,
   input  logic [3:0] crystal_7_line,
   input  logic [3:0] crystal_8_line,
   output logic       busy,
   output logic       done,
   output logic       chain_valid,
   output logic [2:0] power_level,
   output logic [1:0] error_code,
   output logic [2:0] bad_slot
);

   typedef enum logic [1:0] {IDLE, CHECK, REPORT} state_t;

   state_t     state_reg, state_next;
   logic [3:0] in_line [8];
   logic [3:0] line_reg [8];
   logic [3:0] line_next [8];
   logic [7:0] visited_reg, visited_next;
   logic [2:0] slot_reg, slot_next;
   logic [2:0] link_reg, link_next;
   logic [1:0] err_code_reg, err_code_next;
   logic [2:0] err_slot_reg, err_slot_next;

   logic       busy_reg, busy_next;
   logic       done_reg, done_next;
   logic       valid_reg, valid_next;
   logic [2:0] power_reg, power_next;
   logic [1:0] code_reg, code_next;
   logic [2:0] bad_slot_reg, bad_slot_next;

   logic [3:0] cur_line;
   logic [3:0] prev_line;
   logic       ordered;

   assign in_line[0] = crystal_A_line;
   assign in_line[1] = crystal_2_line;
   assign in_line[2] = crystal_3_line;
   assign in_line[3] = crystal_4_line;
   assign in_line[4] = crystal_5_line;
   assign in_line[5] = crystal_6_line;
   assign in_line[6] = crystal_7_line;
   assign in_line[7] = crystal_8_line;

   assign cur_line  = line_reg[slot_reg];
   // Slot 0 wraps to slot 7 here, but ordered is gated off for slot 0.
   assign prev_line = line_reg[slot_reg - 3'd1];
   // Bit 3 set means the line is out of range (8..15), so no link is counted.
   assign ordered   = (slot_reg != 3'd0) && !cur_line[3] && !prev_line[3] &&
                      (cur_line[2:0] == prev_line[2:0] + LINK_STEP);

   always_comb begin
      state_next    = state_reg;
      line_next     = line_reg;
      visited_next  = visited_reg;
      slot_next     = slot_reg;
      link_next     = link_reg;
      err_code_next = err_code_reg;
      err_slot_next = err_slot_reg;
      busy_next     = busy_reg;
      done_next     = 1'b0;
      valid_next    = valid_reg;
      power_next    = power_reg;
      code_next     = code_reg;
      bad_slot_next = bad_slot_reg;

      case (state_reg)
         IDLE: begin
            if (start) begin
               line_next     = in_line;
               visited_next  = '0;
               slot_next     = '0;
               link_next     = '0;
               err_code_next = '0;
               err_slot_next = '0;
               busy_next     = 1'b1;
               state_next    = CHECK;
            end
         end
         CHECK: begin
            if (cur_line[3]) begin
               if (err_code_reg == 2'd0) begin
                  err_code_next = 2'd1;
                  err_slot_next = slot_reg;
               end
            end else if (visited_reg[cur_line[2:0]]) begin
               if (err_code_reg == 2'd0) begin
                  err_code_next = 2'd2;
                  err_slot_next = slot_reg;
               end
            end else begin
               visited_next[cur_line[2:0]] = 1'b1;
            end
            if (ordered && (link_reg != 3'd7))
               link_next = link_reg + 3'd1;
            slot_next = slot_reg + 3'd1;
            if (slot_reg == 3'd7)
               state_next = REPORT;
         end
         REPORT: begin
            // Slot 7's updates landed on the previous edge, so the
            // first-error and link registers are final here.
            done_next     = 1'b1;
            valid_next    = (err_code_reg == 2'd0);
            power_next    = (err_code_reg == 2'd0) ? link_reg : 3'd0;
            code_next     = err_code_reg;
            bad_slot_next = err_slot_reg;
            busy_next     = 1'b0;
            state_next    = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge system_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         for (int i = 0; i < 8; i++) line_reg[i] <= '0;
         visited_reg  <= '0;
         slot_reg     <= '0;
         link_reg     <= '0;
         err_code_reg <= '0;
         err_slot_reg <= '0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         valid_reg    <= 1'b0;
         power_reg    <= '0;
         code_reg     <= '0;
         bad_slot_reg <= '0;
      end else begin
         state_reg    <= state_next;
         line_reg     <= line_next;
         visited_reg  <= visited_next;
         slot_reg     <= slot_next;
         link_reg     <= link_next;
         err_code_reg <= err_code_next;
         err_slot_reg <= err_slot_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
         valid_reg    <= valid_next;
         power_reg    <= power_next;
         code_reg     <= code_next;
         bad_slot_reg <= bad_slot_next;
      end
   end

   assign busy        = busy_reg;
   assign done        = done_reg;
   assign chain_valid = valid_reg;
   assign power_level = power_reg;
   assign error_code  = code_reg;
   assign bad_slot    = bad_slot_reg;

endmodule
